bcd_timer_n: RTL

Parametrised BCD countdown/count-up timer, the generalised successor of the fixed 9-digit H:M:S.ms timer. It supports configurable digit count, per-digit radix, an external tick strobe, pause/resume, stopwatch (count-up) mode and cursor-based editing. It sits between the debounced button pulses and the seven-segment display driver.

---
 rtl/bcd_timer_n.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/bcd_timer_n.sv
// Parametrised BCD countdown/count-up timer with pause, stopwatch mode and cursor editing.
// Optional macro BCD_TIMER_AUTORELOAD_EN: reload the edited preset when a countdown reaches zero.
module bcd_timer_n #(
    parameter int                NDIG    = 9,
    parameter logic [4*NDIG-1:0] DIG_MAX = 36'h995959999,
    parameter int                EDIT_LO = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    mode,
    input  logic                    btn_c,
    input  logic                    btn_l,
    input  logic                    btn_r,
    input  logic                    btn_u,
    input  logic                    btn_d,
    output logic [4*NDIG-1:0]       count_o,
    output logic [$clog2(NDIG)-1:0] cursor_o,
    output logic                    edit_o,
    output logic                    run_o,
    output logic                    done_o
);

    localparam int              W       = 4 * NDIG;
    localparam int              CW      = $clog2(NDIG);
    localparam logic [CW-1:0]   CUR_TOP = CW'(NDIG - 1);
    localparam logic [CW-1:0]   CUR_LO  = CW'(EDIT_LO);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        EDIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_n;
    logic [W-1:0]    count_q, count_n;
    logic [CW-1:0]   cursor_q, cursor_n;
    logic            edit_q, run_q, done_q;
    logic            done_pulse;
    logic            exit_edit;
`ifdef BCD_TIMER_AUTORELOAD_EN
    logic [W-1:0]    preset_q, preset_n;
    logic            reload_q, reload_n;
`endif

    // Whole-count decrement; each digit at 0 wraps to its own maximum and borrows.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = DIG_MAX[4*i +: 4];
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == DIG_MAX[4*i +: 4]) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Single-digit edits wrap within the digit and never touch neighbours.
    function automatic logic [3:0] digit_up(input logic [3:0] d, input logic [3:0] m);
        return (d == m) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] digit_dn(input logic [3:0] d, input logic [3:0] m);
        return (d == 4'd0) ? m : d - 4'd1;
    endfunction

    always_comb begin
        state_n    = state_q;
        count_n    = count_q;
        cursor_n   = cursor_q;
        done_pulse = 1'b0;
        exit_edit  = 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
        preset_n   = preset_q;
        reload_n   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (btn_c) begin
                    if (mode || (count_q != '0)) state_n = RUN;
                end else if (btn_l || btn_r) begin
                    state_n  = EDIT;
                    cursor_n = CUR_TOP;
                    for (int i = 0; i < EDIT_LO; i++) count_n[4*i +: 4] = 4'd0;
                end else if (btn_d) begin
                    count_n = '0;
                end
            end
            RUN: begin
                if (btn_c) begin
                    state_n = IDLE;
`ifdef BCD_TIMER_AUTORELOAD_EN
                end else if (reload_q) begin
                    count_n = preset_q;
`endif
                end else if (tick) begin
                    if (!mode) begin
                        count_n = bcd_dec(count_q);
                        if (count_n == '0) begin
`ifdef BCD_TIMER_AUTORELOAD_EN
                            if (preset_q != '0) begin
                                reload_n   = 1'b1;
                                done_pulse = 1'b1;
                            end else begin
                                state_n = DONE;
                            end
`else
                            state_n = DONE;
`endif
                        end
                    end else if (count_q == DIG_MAX) begin
                        state_n = DONE;
                    end else begin
                        count_n = bcd_inc(count_q);
                    end
                end
            end
            EDIT: begin
                if (btn_c) begin
                    exit_edit = 1'b1;
                end else if (btn_l) begin
                    if (cursor_q == CUR_TOP) exit_edit = 1'b1;
                    else                     cursor_n  = cursor_q + CW'(1);
                end else if (btn_r) begin
                    if (cursor_q == CUR_LO) exit_edit = 1'b1;
                    else                    cursor_n  = cursor_q - CW'(1);
                end else if (btn_u || btn_d) begin
                    for (int i = 0; i < NDIG; i++) begin
                        if (cursor_q == CW'(i)) begin
                            count_n[4*i +: 4] = btn_u
                                ? digit_up(count_q[4*i +: 4], DIG_MAX[4*i +: 4])
                                : digit_dn(count_q[4*i +: 4], DIG_MAX[4*i +: 4]);
                        end
                    end
                end
            end
            DONE: begin
                if (btn_c) begin
                    state_n = IDLE;
                end else if (btn_l || btn_r) begin
                    state_n  = EDIT;
                    cursor_n = CUR_TOP;
                    for (int i = 0; i < EDIT_LO; i++) count_n[4*i +: 4] = 4'd0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (exit_edit) begin
            state_n  = IDLE;
            cursor_n = CUR_TOP;
`ifdef BCD_TIMER_AUTORELOAD_EN
            preset_n = count_n;
`endif
        end
    end

    // Status flags are registered from next-state so they align with count_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            cursor_q <= CUR_TOP;
            edit_q   <= 1'b0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
            preset_q <= '0;
            reload_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            count_q  <= count_n;
            cursor_q <= cursor_n;
            edit_q   <= (state_n == EDIT);
            run_q    <= (state_n == RUN);
            done_q   <= (state_n == DONE) || done_pulse;
`ifdef BCD_TIMER_AUTORELOAD_EN
            preset_q <= preset_n;
            reload_q <= reload_n;
`endif
        end
    end

    assign count_o  = count_q;
    assign cursor_o = cursor_q;
    assign edit_o   = edit_q;
    assign run_o    = run_q;
    assign done_o   = done_q;

endmodule
